// File: rtl/execute_muldiv_unit.sv
// execute_muldiv_unit: iterative RV32M-style multiply/divide, one shift-add or
// restoring-subtract step per cycle, with a valid/ready result handshake.
module execute_muldiv_unit #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [RD_W-1:0] i_rd,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [RD_W-1:0] o_rd,
  output logic            o_busy
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic neg_q, neg_d;
  logic [XLEN:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d, a_q, a_d, res_q, res_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic a_sgn, b_sgn, sa, sb, div_zero, ovf;
  logic [XLEN-1:0] ma, mb, byp_res, quo, rem, fin;
  logic [XLEN:0] mul_s, sh, step_hi;
  logic [XLEN+1:0] diff;
  logic [XLEN-1:0] step_lo;
  logic [2*XLEN-1:0] prod;
  always_comb begin
    a_sgn = i_op[2] ? ~i_op[0] : (i_op[1:0] != 2'b11);
    b_sgn = i_op[2] ? ~i_op[0] : ~i_op[1];
    sa = a_sgn & i_rs1[XLEN-1];
    sb = b_sgn & i_rs2[XLEN-1];
    ma = sa ? -i_rs1 : i_rs1;
    mb = sb ? -i_rs2 : i_rs2;
    div_zero = i_op[2] && (i_rs2 == '0);
    ovf = i_op[2] && !i_op[0] && (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&i_rs2);
    byp_res = div_zero ? (i_op[1] ? i_rs1 : '1) : (i_op[1] ? '0 : i_rs1);
    // hi:lo is the running product (shift right) or remainder:quotient (shift left)
    mul_s = lo_q[0] ? hi_q + {1'b0, a_q} : hi_q;
    sh = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    diff = {1'b0, sh} - {2'b00, a_q};
    step_hi = op_q[2] ? (diff[XLEN+1] ? sh : diff[XLEN:0]) : {1'b0, mul_s[XLEN:1]};
    step_lo = op_q[2] ? {lo_q[XLEN-2:0], ~diff[XLEN+1]} : {mul_s[0], lo_q[XLEN-1:1]};
    prod = {step_hi[XLEN-1:0], step_lo};
    prod = neg_q ? -prod : prod;
    quo = neg_q ? -step_lo : step_lo;
    rem = neg_q ? -step_hi[XLEN-1:0] : step_hi[XLEN-1:0];
    fin = op_q[2] ? (op_q[1] ? rem : quo) : (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    neg_d = neg_q;
    hi_d = hi_q;
    lo_d = lo_q;
    a_d = a_q;
    res_d = res_q;
    rd_d = rd_q;
    if (state_q == IDLE && i_valid && !i_flush) begin
      op_d = i_op;
      rd_d = i_rd;
      neg_d = (i_op[2] && i_op[1]) ? sa : sa ^ sb;
      a_d = mb;
      lo_d = ma;
      hi_d = '0;
      cnt_d = '0;
      state_d = (div_zero || ovf) ? DONE : CALC;
      res_d = byp_res;
    end else if (state_q == CALC) begin
      hi_d = step_hi;
      lo_d = step_lo;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(XLEN-1)) begin
        state_d = DONE;
        res_d = fin;
      end
    end else if (state_q == DONE && i_ready) begin
      state_d = IDLE;
    end
    if (i_flush) state_d = IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      neg_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      a_q <= '0;
      res_q <= '0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      neg_q <= neg_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      a_q <= a_d;
      res_q <= res_d;
      rd_q <= rd_d;
    end
  end
  assign o_ready = (state_q == IDLE) && !i_flush;
  assign o_busy = state_q != IDLE;
  assign o_valid = state_q == DONE;
  assign o_result = o_valid ? res_q : '0;
  assign o_rd = o_valid ? rd_q : '0;
endmodule

// File: tb/tb_execute_muldiv_unit.sv
// tb_execute_muldiv_unit: directed vectors for execute_muldiv_unit (XLEN=32).
module tb_execute_muldiv_unit;
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_valid = 1'b0, i_flush = 1'b0, i_ready = 1'b1;
  logic [2:0] i_op = '0;
  logic [31:0] i_rs1 = '0, i_rs2 = '0;
  logic [4:0] i_rd = '0;
  logic o_ready, o_valid, o_busy;
  logic [31:0] o_result;
  logic [4:0] o_rd;
  int n_chk = 0, n_fail = 0;

  execute_muldiv_unit #(.XLEN(32), .RD_W(5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_rd(o_rd),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive a request on a negedge; returns on the negedge after the accept edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input string tag);
    @(negedge i_clk);
    i_valid = 1'b1; i_op = op; i_rs1 = a; i_rs2 = b; i_rd = rd;
    check({tag, " ready"}, o_ready, 1);
    @(negedge i_clk);
    i_valid = 1'b0; i_op = 3'b101; i_rs1 = 32'hdead_beef; i_rs2 = 32'h1234_5678; i_rd = 5'h1f;
  endtask

  // latency in accept-relative edges at which o_valid is sampled high
  task automatic wait_valid(output int lat);
    int n = 0;
    while (!o_valid && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    lat = n + 1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int exp_lat,
                       input string tag);
    int lat;
    issue(op, a, b, rd, tag);
    wait_valid(lat);
    check({tag, " lat"}, lat, exp_lat);
    check({tag, " result"}, o_result, exp);
    check({tag, " rd"}, o_rd, rd);
    @(negedge i_clk);
    check({tag, " pulse"}, o_valid, 0);
    check({tag, " res0"}, o_result, 0);
  endtask

  initial begin
    int lat, seen;
    logic [31:0] held;
    repeat (3) @(negedge i_clk);
    check("rst valid", o_valid, 0);
    check("rst busy", o_busy, 0);
    check("rst result", o_result, 0);
    check("rst rd", o_rd, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst ready", o_ready, 1);

    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 33, "mul");
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 33, "mulhu");
    do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000, 33, "mulh");
    do_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'hFFFF_FFFF, 33, "mulhsu");
    do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'h8000_0000, 33, "mulhsu_min");
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 33, "div_neg");
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 33, "rem_neg");
    do_op(3'b101, 32'd20, 32'd3, 5'd8, 32'd6, 33, "divu");
    do_op(3'b111, 32'd20, 32'd3, 5'd9, 32'd2, 33, "remu");
    do_op(3'b100, 32'd100, 32'hFFFF_FFF9, 5'd10, 32'hFFFF_FFF2, 33, "div_negdiv");
    do_op(3'b110, 32'd100, 32'hFFFF_FFF9, 5'd11, 32'd2, 33, "rem_negdiv");
    do_op(3'b100, 32'h8000_0000, 32'd1, 5'd12, 32'h8000_0000, 33, "div_min1");
    do_op(3'b100, 32'd20, 32'd0, 5'd13, 32'hFFFF_FFFF, 1, "div0");
    do_op(3'b110, 32'd20, 32'd0, 5'd14, 32'd20, 1, "rem0");
    do_op(3'b101, 32'd20, 32'd0, 5'd15, 32'hFFFF_FFFF, 1, "divu0");
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1, "div_ovf");
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 1, "rem_ovf");

    // backpressure: five stalled cycles in DONE, consumed on the sixth
    i_ready = 1'b0;
    issue(3'b101, 32'd20, 32'd3, 5'd18, "stall");
    wait_valid(lat);
    check("stall lat", lat, 33);
    held = o_result;
    check("stall result", held, 6);
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      check("stall hold result", o_result, 6);
      check("stall hold rd", o_rd, 18);
      check("stall ready low", o_ready, 0);
      check("stall valid", o_valid, 1);
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    check("stall consumed", o_valid, 0);
    check("stall ready back", o_ready, 1);

    // flush in IDLE blocks acceptance
    i_valid = 1'b1; i_op = 3'b000; i_rs1 = 32'd3; i_rs2 = 32'd3; i_flush = 1'b1;
    #1 check("flush idle ready", o_ready, 0);
    @(negedge i_clk);
    i_valid = 1'b0; i_flush = 1'b0;
    check("flush idle busy", o_busy, 0);

    // flush mid-CALC, then reset mid-CALC
    issue(3'b000, 32'd11, 32'd13, 5'd20, "flush_op");
    repeat (9) @(negedge i_clk);
    check("flush calc busy", o_busy, 1);
    i_flush = 1'b1;
    #1 check("flush ready low", o_ready, 0);
    @(negedge i_clk);
    i_flush = 1'b0;
    check("flush busy", o_busy, 0);
    check("flush valid", o_valid, 0);
    issue(3'b001, 32'd5, 32'd9, 5'd21, "rst_op");
    repeat (5) @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    check("midrst busy", o_busy, 0);
    check("midrst valid", o_valid, 0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (o_valid) seen++;
    end
    check("no stray valid", seen, 0);
    do_op(3'b000, 32'd12345, 32'd678, 5'd22, 32'd8369910, 33, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
